// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared types for the data-memory responder: request and
//                response structs, FSM state encoding, register record and
//                its reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int c_BYTE_LANES = 4;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_type;

    // addr holds the request offset relative to the window base, so the
    // word index is a plain slice of it.
    typedef struct packed {
        dmem_state_type state;
        logic [3:0]     counter;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        logic [3:0]     wstrb;
        logic           in_range;
        logic           ready;
        logic           rd_valid;
        logic           err;
    } dmem_responder_reg_type;

    localparam dmem_responder_reg_type init_dmem_responder_reg = '{
        state:    IDLE,
        counter:  4'd0,
        addr:     32'd0,
        wdata:    32'd0,
        wstrb:    4'd0,
        in_range: 1'b0,
        ready:    1'b0,
        rd_valid: 1'b0,
        err:      1'b0
    };

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : Single-port 32-bit SRAM with per-byte write enables and a
//                synchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [c_BYTE_LANES-1:0] we,
    input  logic [AW-1:0]          addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < c_BYTE_LANES; i++) begin
                if (we[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder. Accepts one load/store at a time,
//                waits WAIT_CYCLES, then answers with a one-cycle mem_ready
//                (and read data for in-range loads, or dmem_err when the
//                address falls outside the window).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        dmem_err
);

    localparam int          c_AW   = $clog2(DEPTH);
    localparam logic [31:0] c_SPAN = 32'(4 * DEPTH);
    localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

    dmem_responder_reg_type r, rin, v;

    logic [31:0]     w_req_off;
    logic            w_req_in_range;
    logic            w_fire;
    logic [31:0]     w_sel_off;
    logic [31:0]     w_sel_wdata;
    logic [3:0]      w_sel_wstrb;
    logic            w_sel_in_range;
    logic            w_ram_en;
    logic [3:0]      w_ram_we;
    logic [c_AW-1:0] w_ram_idx;
    logic [31:0]     w_ram_rdata;
    logic            w_unused;

    // Unsigned wrap of the subtraction folds "below base" into "above span".
    assign w_req_off      = dmem_in.mem_addr - BASE_ADDR;
    assign w_req_in_range = (w_req_off < c_SPAN);

    // The access completing at this edge is the latched one when leaving
    // WAIT, otherwise the request being accepted right now (zero wait).
    assign w_sel_off      = (r.state == WAIT) ? r.addr     : w_req_off;
    assign w_sel_wdata    = (r.state == WAIT) ? r.wdata    : dmem_in.mem_wdata;
    assign w_sel_wstrb    = (r.state == WAIT) ? r.wstrb    : dmem_in.mem_wstrb;
    assign w_sel_in_range = (r.state == WAIT) ? r.in_range : w_req_in_range;

    // Next-state, request latching and RAM port control.
    always_comb begin
        v          = r;
        v.ready    = 1'b0;
        v.rd_valid = 1'b0;
        v.err      = 1'b0;
        w_fire     = 1'b0;

        case (r.state)
            IDLE, RESP: begin
                if (dmem_in.mem_valid) begin
                    v.addr     = w_req_off;
                    v.wdata    = dmem_in.mem_wdata;
                    v.wstrb    = dmem_in.mem_wstrb;
                    v.in_range = w_req_in_range;
                    v.counter  = 4'd0;
                    if (c_WAIT == 4'd0) begin
                        v.state = RESP;
                        w_fire  = 1'b1;
                    end else begin
                        v.state = WAIT;
                    end
                end else begin
                    v.state = IDLE;
                end
            end
            WAIT: begin
                v.counter = r.counter + 4'd1;
                if (v.counter == c_WAIT) begin
                    v.state = RESP;
                    w_fire  = 1'b1;
                end
            end
            default: v.state = IDLE;
        endcase

        if (w_fire) begin
            v.ready    = 1'b1;
            v.err      = ~w_sel_in_range;
            v.rd_valid = w_sel_in_range && (w_sel_wstrb == 4'd0);
        end

        // A reset on the completing edge must not commit the store.
        w_ram_en  = w_fire && w_sel_in_range && !rst;
        w_ram_we  = w_ram_en ? w_sel_wstrb : 4'd0;
        w_ram_idx = w_sel_off[c_AW+1:2];

        rin = v;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= init_dmem_responder_reg;
        end else begin
            r <= rin;
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_idx),
        .wdata (w_sel_wdata),
        .rdata (w_ram_rdata)
    );

    assign dmem_out.mem_ready = r.ready;
    assign dmem_out.mem_rdata = r.rd_valid ? w_ram_rdata : 32'd0;
    assign dmem_err           = r.err;

    // mem_instr carries no meaning here; offset bits outside the index are
    // only consumed by the range compare.
    assign w_unused = ^{dmem_in.mem_instr, w_sel_off};

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder: a zero-wait
//                instance driven back-to-back and a three-wait instance
//                driven one request at a time, both against a word-array
//                reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int D0 = 1024;
    localparam int D1 = 64;
    localparam int W1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    mem_in_type  din0, din1;
    mem_out_type dout0, dout1;
    logic        err0, err1;

    dmem_responder #(.DEPTH(D0), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst0), .dmem_in(din0), .dmem_out(dout0), .dmem_err(err0));

    dmem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst1), .dmem_in(din1), .dmem_out(dout1), .dmem_err(err1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference memories: word index -> contents, only for words with a
    // fully known value.
    logic [31:0] ref0 [int unsigned];
    logic [31:0] ref1 [int unsigned];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (st[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    function automatic void predict(input int s, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] st, output logic [31:0] rd,
                                    output logic er, output bit known);
        int unsigned depth;
        int unsigned idx;
        depth = (s == 0) ? D0 : D1;
        rd = 32'd0; er = 1'b0; known = 1'b1;
        if (a >= 32'(4 * depth)) begin
            er = 1'b1;
            return;
        end
        idx = a >> 2;
        if (st != 4'd0) begin
            if (s == 0) begin
                if (ref0.exists(idx)) ref0[idx] = merge(ref0[idx], d, st);
                else if (st == 4'hF) ref0[idx] = d;
            end else begin
                if (ref1.exists(idx)) ref1[idx] = merge(ref1[idx], d, st);
                else if (st == 4'hF) ref1[idx] = d;
            end
        end else begin
            if (s == 0 && ref0.exists(idx)) rd = ref0[idx];
            else if (s == 1 && ref1.exists(idx)) rd = ref1[idx];
            else known = 1'b0;
        end
    endfunction

    function automatic void gen(input int unsigned depth, output logic [31:0] a,
                                output logic [31:0] d, output logic [3:0] st);
        int unsigned r;
        r  = $urandom_range(0, 9);
        a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if (r == 0) a = 32'(4 * depth + $urandom_range(0, 255));
        d  = $urandom;
        st = (r < 4) ? 4'h0 : ((r < 7) ? 4'hF : 4'($urandom_range(1, 15)));
    endfunction

    // Zero-wait instance: each step checks the response to the request
    // driven on the previous step, then drives the next one.
    bit          p_v = 1'b0;
    logic [31:0] p_rd;
    logic        p_er;
    bit          p_known;
    string       p_tag = "reset";

    task automatic step0(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st, input string tag, output logic [31:0] prev_rd);
        @(negedge clk);
        prev_rd = dout0.mem_rdata;
        if (p_v) begin
            chk({p_tag, " ready"}, dout0.mem_ready, 1);
            chk({p_tag, " err"}, err0, p_er);
            if (p_known) chk({p_tag, " rdata"}, dout0.mem_rdata, p_rd);
        end else begin
            chk({p_tag, " idle outputs"}, {dout0.mem_ready, err0, dout0.mem_rdata}, 0);
        end
        p_v   = v;
        p_tag = tag;
        if (v) predict(0, a, d, st, p_rd, p_er, p_known);
        din0 = '{mem_valid: v, mem_instr: 1'($urandom), mem_addr: a, mem_wdata: d, mem_wstrb: st};
    endtask

    // Three-wait instance: one full transaction, inputs scrambled after
    // acceptance, latency counted in cycles from the acceptance edge.
    task automatic xact1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        din1 = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: a, mem_wdata: d, mem_wstrb: st};
        @(negedge clk);
        din1 = '{mem_valid: 1'b0, mem_instr: 1'b0, mem_addr: $urandom, mem_wdata: $urandom,
                 mem_wstrb: 4'($urandom)};
        lat = 1;
        while (dout1.mem_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = dout1.mem_rdata;
        er = err1;
    endtask

    task automatic op1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                       input string tag);
        logic [31:0] erd, rd;
        logic        eer, er;
        bit          kn;
        int          lat;
        predict(1, a, d, st, erd, eer, kn);
        xact1(a, d, st, lat, rd, er);
        chk({tag, " latency"}, lat, W1 + 1);
        chk({tag, " err"}, er, eer);
        if (kn) chk({tag, " rdata"}, rd, erd);
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  st;

        rst0 = 1'b1; rst1 = 1'b1;
        din0 = '0;   din1 = '0;
        repeat (3) @(negedge clk);
        chk("reset dut0", {dout0.mem_ready, err0, dout0.mem_rdata}, 0);
        chk("reset dut1", {dout1.mem_ready, err1, dout1.mem_rdata}, 0);
        rst0 = 1'b0; rst1 = 1'b0;

        // ---- zero-wait instance, directed ----
        step0(1, 32'h10,   32'hDEADBEEF, 4'hF,    "st10",   rd);
        step0(1, 32'h10,   32'h0,        4'h0,    "ld10",   rd);
        step0(1, 32'h20,   32'h11223344, 4'hF,    "st20",   rd);
        chk("w0 load after store", rd, 32'hDEADBEEF);
        step0(1, 32'h20,   32'h0000AB00, 4'b0010, "pst20",  rd);
        step0(1, 32'h22,   32'h0,        4'h0,    "ld20",   rd);
        step0(1, 32'h1000, 32'h0,        4'h0,    "ld_oor", rd);
        chk("w0 partial store merge", rd, 32'h1122AB44);
        step0(1, 32'h1010, 32'h0,        4'hF,    "st_oor", rd);
        step0(1, 32'h10,   32'h0,        4'h0,    "ld10b",  rd);
        step0(0, 32'h0,    32'h0,        4'h0,    "idle",   rd);
        chk("w0 ram unchanged by oor store", rd, 32'hDEADBEEF);
        step0(0, 32'h0,    32'h0,        4'h0,    "idle",   rd);

        // ---- zero-wait instance, random back-to-back ----
        for (int k = 0; k < 150; k++) begin
            gen(D0, a, d, st);
            step0(($urandom_range(0, 7) != 0), a, d, st, $sformatf("w0 rnd%0d", k), rd);
        end
        step0(0, 32'h0, 32'h0, 4'h0, "drain", rd);
        step0(0, 32'h0, 32'h0, 4'h0, "drain", rd);

        // ---- three-wait instance, directed ----
        op1(32'h10, 32'h55AA55AA, 4'hF, "w3 st10");
        op1(32'h40, 32'h0BADF00D, 4'hF, "w3 st40");
        @(negedge clk);
        din1 = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h10, mem_wdata: 32'h0, mem_wstrb: 4'h0};
        @(negedge clk);
        chk("w3 no ready t+1", dout1.mem_ready, 0);
        din1 = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h40, mem_wdata: 32'hFFFFFFFF, mem_wstrb: 4'hF};
        @(negedge clk);
        chk("w3 no ready t+2", dout1.mem_ready, 0);
        @(negedge clk);
        chk("w3 no ready t+3", dout1.mem_ready, 0);
        din1.mem_valid = 1'b0;
        @(negedge clk);
        chk("w3 ready t+4", dout1.mem_ready, 1);
        chk("w3 rdata t+4", dout1.mem_rdata, 32'h55AA55AA);
        chk("w3 err t+4", err1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w3 pulses in wait ignored", dout1.mem_ready, 0);
        end
        op1(32'h40,  32'h0, 4'h0, "w3 ld40");
        op1(32'h100, 32'h0, 4'h0, "w3 ld_oor");
        op1(32'h30,  32'h12345678, 4'hF, "w3 st30");

        // Reset asserted on the edge that would commit a store to 0x30.
        @(negedge clk);
        din1 = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h30, mem_wdata: 32'hCAFEF00D, mem_wstrb: 4'hF};
        @(negedge clk);
        din1.mem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("w3 no ready after reset", dout1.mem_ready, 0);
            @(negedge clk);
        end
        op1(32'h30, 32'h0, 4'h0, "w3 ld30 after reset");

        // ---- three-wait instance, random ----
        for (int k = 0; k < 40; k++) begin
            gen(D1, a, d, st);
            op1(a, d, st, $sformatf("w3 rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_responder
`default_nettype wire
